// File: rtl/keypad_scan_dev.sv
// 4x4 active-low matrix keypad scanner with row synchronizer, debounce,
// one-cycle key strobe and a four-deep history of key codes.
module keypad_scan_dev #(
  parameter int unsigned SCAN_TICKS = 50000,
  parameter int unsigned DB_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] key_buf
);

  localparam logic [1:0] ST_SCAN    = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [31:0] SCAN_LAST = 32'(SCAN_TICKS - 1);
  localparam logic [31:0] DB_LAST   = 32'(DB_CYCLES - 1);

  // Lowest-numbered active (low) row wins when several are pressed.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  logic [3:0]  row_meta_r, row_sync_r;
  logic [1:0]  state_r, state_nxt_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic [1:0]  col_idx_r, col_nxt_s;
  logic [1:0]  row_lat_r, row_lat_nxt_s;
  logic [3:0]  code_nxt_s;
  logic [15:0] buf_nxt_s;
  logic        valid_nxt_s, down_nxt_s;
  logic        row_up_s;

  assign row_up_s = row_sync_r[row_lat_r];

  // Next-state and output computation for the scan/debounce FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r + 32'd1;
    col_nxt_s     = col_idx_r;
    row_lat_nxt_s = row_lat_r;
    code_nxt_s    = key_code;
    buf_nxt_s     = key_buf;
    valid_nxt_s   = 1'b0;
    down_nxt_s    = key_down;
    case (state_r)
      ST_SCAN: begin
        if (cnt_r == SCAN_LAST) begin
          cnt_nxt_s = 32'd0;
          if (row_sync_r != 4'hF) begin
            row_lat_nxt_s = low_row(row_sync_r);
            state_nxt_s   = ST_DEBOUNCE;
          end else begin
            col_nxt_s = col_idx_r + 2'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_up_s) begin
          state_nxt_s = ST_SCAN;
          cnt_nxt_s   = 32'd0;
          col_nxt_s   = col_idx_r + 2'd1;
        end else if (cnt_r == DB_LAST) begin
          code_nxt_s  = {row_lat_r, col_idx_r};
          buf_nxt_s   = {key_buf[11:0], row_lat_r, col_idx_r};
          valid_nxt_s = 1'b1;
          down_nxt_s  = 1'b1;
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = 32'd0;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      ST_HOLD: begin
        // Counter parked at zero so a long hold cannot wrap it.
        cnt_nxt_s = 32'd0;
        if (row_up_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_RELEASE: begin
        if (!row_up_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = 32'd0;
        end else if (cnt_r == DB_LAST) begin
          down_nxt_s  = 1'b0;
          state_nxt_s = ST_SCAN;
          cnt_nxt_s   = 32'd0;
          col_nxt_s   = col_idx_r + 2'd1;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        state_nxt_s = ST_SCAN;
        cnt_nxt_s   = 32'd0;
      end
    endcase
  end

  // Row synchronizer; idle (all high) after reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // FSM state and registered outputs; column drive decoded from the next index.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r   <= ST_SCAN;
      cnt_r     <= 32'd0;
      col_idx_r <= 2'd0;
      row_lat_r <= 2'd0;
      col_out   <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_buf   <= 16'h0000;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      col_idx_r <= col_nxt_s;
      row_lat_r <= row_lat_nxt_s;
      col_out   <= ~(4'b0001 << col_nxt_s);
      key_code  <= code_nxt_s;
      key_valid <= valid_nxt_s;
      key_down  <= down_nxt_s;
      key_buf   <= buf_nxt_s;
    end
  end

endmodule

// File: tb/tb_keypad_scan_dev.sv
// Directed bench for keypad_scan_dev with a behavioural 4x4 keypad model
// (SCAN_TICKS=4, DB_CYCLES=8).
module tb_keypad_scan_dev;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] key_buf;

  logic [15:0] keys;   // bit r*4+c set = key (row r, col c) held
  int          n_vec  = 0;
  int          n_bad  = 0;
  int          pulses = 0;

  keypad_scan_dev #(.SCAN_TICKS(4), .DB_CYCLES(8)) dut (
    .clk(clk), .clr_n(clr_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .key_buf(key_buf)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid) pulses++;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] exp_buf;
  } key_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_up(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!key_down) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    key_vec_t   seq[5];
    logic [3:0] col_tab[4];
    bit         ok, flag;
    int         base;
    logic [3:0] seen;

    seq[0] = '{4'h1, 16'h0091};
    seq[1] = '{4'h2, 16'h0912};
    seq[2] = '{4'h3, 16'h9123};
    seq[3] = '{4'h4, 16'h1234};
    seq[4] = '{4'h5, 16'h2345};
    col_tab[0] = 4'b1110; col_tab[1] = 4'b1101;
    col_tab[2] = 4'b1011; col_tab[3] = 4'b0111;

    keys  = 16'h0000;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_down", key_down, 1'b0);
    check("rst_key_buf", key_buf, 16'h0000);

    // Idle sweep: column changes every 4 cycles after reset release.
    clr_n = 1'b1;
    base = pulses;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("sweep_col", col_out, col_tab[(k/4)%4]);
    end
    check("sweep_no_valid", pulses - base, 0);
    check("sweep_buf", key_buf, 16'h0000);

    // Key (row 2, col 1) held continuously.
    base = pulses;
    keys = 16'h0200;
    wait_valid(80, ok);
    check("k9_valid_seen", ok, 1'b1);
    check("k9_code", key_code, 4'h9);
    check("k9_buf", key_buf, 16'h0009);
    check("k9_down", key_down, 1'b1);
    flag = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (col_out !== 4'b1101 || !key_down) flag = 1'b0;
    end
    check("k9_col_frozen", flag, 1'b1);
    check("k9_one_pulse", pulses - base, 1);
    keys = 16'h0000;
    wait_up(40, ok);
    check("k9_release", ok, 1'b1);
    repeat (20) @(negedge clk);

    // Sequence of keys 1..5 shifting into the history.
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      keys = 16'h0001 << seq[i].code;
      wait_valid(80, ok);
      check("seq_valid_seen", ok, 1'b1);
      check("seq_code", key_code, seq[i].code);
      check("seq_buf", key_buf, seq[i].exp_buf);
      repeat (20) @(negedge clk);
      keys = 16'h0000;
      wait_up(40, ok);
      check("seq_release", ok, 1'b1);
      repeat (20) @(negedge clk);
    end
    check("seq_pulses", pulses - base, 5);
    check("seq_final_buf", key_buf, 16'h2345);

    // Bouncing press (low 3, high 2) never gets accepted.
    do_reset();
    base = pulses;
    for (int rep = 0; rep < 12; rep++) begin
      keys = 16'h0040;
      repeat (3) @(negedge clk);
      keys = 16'h0000;
      repeat (2) @(negedge clk);
    end
    check("bounce_no_valid", pulses - base, 0);
    check("bounce_down", key_down, 1'b0);
    repeat (10) @(negedge clk);
    seen = 4'h0;
    repeat (16) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (col_out == col_tab[c]) seen[c] = 1'b1;
    end
    check("bounce_scan_resumes", seen, 4'hF);

    // Held key with a 3-cycle release glitch, then a clean release.
    base = pulses;
    keys = 16'h2000;
    wait_valid(80, ok);
    check("glitch_valid_seen", ok, 1'b1);
    check("glitch_code", key_code, 4'hD);
    repeat (5) @(negedge clk);
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    keys = 16'h2000;
    flag = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!key_down) flag = 1'b0;
    end
    check("glitch_down_held", flag, 1'b1);
    keys = 16'h0000;
    repeat (10) @(negedge clk);
    check("release_down_before", key_down, 1'b1);
    @(negedge clk);
    check("release_down_after", key_down, 1'b0);
    check("glitch_one_pulse", pulses - base, 1);
    repeat (10) @(negedge clk);

    // Rows 1 and 3 on column 2: row 1 wins and is the only row tracked.
    base = pulses;
    keys = 16'h4040;
    wait_valid(80, ok);
    check("multi_valid_seen", ok, 1'b1);
    check("multi_code", key_code, 4'h6);
    repeat (5) @(negedge clk);
    keys = 16'h4000;
    repeat (11) @(negedge clk);
    check("multi_row1_release", key_down, 1'b0);
    keys = 16'h0000;
    repeat (20) @(negedge clk);
    check("multi_one_pulse", pulses - base, 1);

    // Reset mid-DEBOUNCE on column 2: press discarded.
    @(negedge clk);
    clr_n = 1'b0;
    keys  = 16'h0004;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    base = pulses;
    repeat (15) @(negedge clk);
    check("mid_db_col", col_out, 4'b1011);
    check("mid_db_no_valid_yet", pulses - base, 0);
    clr_n = 1'b0;
    #1;
    check("async_rst_col", col_out, 4'b1110);
    check("async_rst_down", key_down, 1'b0);
    check("async_rst_valid", key_valid, 1'b0);
    repeat (2) @(negedge clk);
    keys  = 16'h0000;
    clr_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_db_discarded", pulses - base, 0);

    // Reset during HOLD clears outputs without a clock edge.
    keys = 16'h0200;
    wait_valid(80, ok);
    check("hold_valid_seen", ok, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_col_pre", col_out, 4'b1101);
    clr_n = 1'b0;
    #1;
    check("hold_rst_col", col_out, 4'b1110);
    check("hold_rst_down", key_down, 1'b0);
    check("hold_rst_code", key_code, 4'h0);
    check("hold_rst_buf", key_buf, 16'h0000);
    keys = 16'h0000;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_dev.md
# keypad_scan_dev

Input-side companion to the seven-segment display driver: scans a 4×4 active-low matrix keypad, synchronizes and debounces the row lines, and reports each accepted key press as a 4-bit code with a one-cycle valid strobe. It also keeps a 16-bit history of the last four key codes, sized to drive the display driver's 16-bit hex field directly. The block sits between the board keypad pins and the CPU I/O bus or display path, in the same clock domain as the display scanner.

## Interface
- SCAN_TICKS, 50000: clock cycles each column is driven while idle-scanning; legal range is 2 or more.
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a press or a release; legal range is 2 or more.
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- row_in  input  4  keypad row lines; active-low with board pull-ups; asynchronous to clk.
- col_out  output  4  keypad column drive; active-low, exactly one bit low at all times.
- key_code  output  4  code of the last accepted key: row_idx*4 + col_idx.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_down  output  1  level; high from acceptance until the debounced release.
- key_buf  output  16  last four codes; newest in [3:0], oldest in [15:12].

## Operation
- row_in passes through a 2-flop synchronizer to produce row_s. Both flops reset to 4'hF. All decisions use row_s only.
- col_out = ~(4'b0001 << col_idx).
- row_idx is the lowest index i with row_s[i]==0 (priority encoder).
- A 32-bit cycle counter cnt serves both the scan dwell and the debounce. It clears on every state change.
- FSM states:
  - SCAN:
    - Counts cnt up to SCAN_TICKS-1 (the tick).
    - At the tick, if row_s != 4'hF: latch col_idx and row_idx, then go to DEBOUNCE. The column stays held.
    - Otherwise col_idx = col_idx+1 mod 4 (3 wraps to 0), and cnt clears.
  - DEBOUNCE:
    - If row_s[latched row]==1: return to SCAN and advance the column.
    - Otherwise, when cnt reaches DB_CYCLES-1, in a single clock edge: key_code <= code; key_buf <= {key_buf[11:0], code}; key_valid <= 1; key_down <= 1; go to HOLD.
  - HOLD:
    - Column held. Other keys are ignored (no rollover).
    - When row_s[latched row]==1, go to RELEASE.
  - RELEASE:
    - If row_s[latched row]==0, return to HOLD (bounce).
    - When cnt reaches DB_CYCLES-1: key_down <= 0, go to SCAN, advance the column.
- key_valid is high for exactly one cycle per accepted press. A held key never repeats.
- Multiple rows low at the tick: the lowest row index wins. Only that row is tracked afterwards.
- Reset values: state=SCAN, col_idx=0, col_out=4'b1110, cnt=0, key_code=0, key_valid=0, key_down=0, key_buf=16'h0000.
- Reset is honoured in any state. A press in progress is discarded with no key_valid pulse.

## Timing
- Synchronizer latency is 2 cycles from a row_in change to row_s.
- Column dwell while idle is SCAN_TICKS cycles. One full keypad sweep is 4·SCAN_TICKS cycles.
- DEBOUNCE is entered on the tick edge, cycle T. If the key stays low, key_valid, key_code, key_buf and key_down all update on edge T+DB_CYCLES.
- A release glitch shorter than DB_CYCLES during HOLD or RELEASE leaves key_down high and produces no new key_valid.
- After release is accepted, scanning resumes on the next column. The dwell counter restarts at 0.
- All outputs are registered. There is no combinational path from row_in to any output.

## Test plan
Bench settings: SCAN_TICKS=4, DB_CYCLES=8.

- Reset release with no key pressed -> col_out cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid=0 and key_buf=0 throughout.
- Key (row 2, col 1) held continuously -> exactly one key_valid pulse, key_code=4'h9, key_buf=16'h0009, key_down=1; col_out frozen at 1101 until release.
- Presses of keys 1, 2, 3, 4, 5 in sequence (each held ≥20 cycles, released ≥20 cycles) -> key_buf ends at 16'h2345, with five key_valid pulses total.
- Press bouncing low for 3 cycles, high for 2, repeated -> no key_valid; FSM returns to SCAN and scanning continues.
- Held key with a 3-cycle high glitch in the middle -> key_down stays 1 and no second key_valid; a clean release of ≥10 cycles drops key_down.
- Rows 1 and 3 low on the same column; separately, clr_n asserted mid-DEBOUNCE -> row 1 is chosen (code = 4+col); the reset asynchronously forces col_out=1110 and key_down=0 with no key_valid pulse.
